harmonic_synth: RTL

Parametrised multi-harmonic tone generator for the note player. One request produces one signed sample: the weighted sum of the fundamental and up to NUM_HARMONICS-1 integer overtones of a 20-bit step_size tone. It sits between the note sequencer, which supplies step_size, play_enable and the sample strobe, and the codec sample path. It replaces the single-harmonic create_harmonic with N time-multiplexed harmonics over one shared sine ROM, per-harmonic weights and output saturation.

---
 rtl/harmonic_synth_pkg.sv | 34 +++
 rtl/harmonic_synth_if.sv | 26 ++
 rtl/sine_lookup.sv | 35 +++
 rtl/sine_rom.sv | 30 +++
 rtl/harmonic_synth.sv | 117 +++++++++++
 5 files changed

// File: rtl/harmonic_synth_pkg.sv
// rtl/harmonic_synth_pkg.sv - shared types and constants for the harmonic tone generator
// Purpose: phase field layout, weight encodings, FSM states and output clamp limits.
// Ports: none (package harmonic_pkg).
package harmonic_pkg;

   localparam int QUAD_W       = 2;
   localparam int ADDR_W       = 10;
   localparam int FRAC_W       = 10;
   localparam int PHASE_W      = QUAD_W + ADDR_W + FRAC_W;
   localparam int STEP_W       = 20;
   localparam int SAMPLE_W_DEF = 16;

   typedef enum logic [1:0] {
      W_ZERO    = 2'd0,
      W_QUARTER = 2'd1,
      W_HALF    = 2'd2,
      W_FULL    = 2'd3
   } weight_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_OUT
   } state_e;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   localparam int SAT_MAX = sat_max(SAMPLE_W_DEF);
   localparam int SAT_MIN = -SAT_MAX - 1;

endpackage

// File: rtl/harmonic_synth_if.sv
// rtl/harmonic_synth_if.sv - sequencer-to-generator request/sample bundle
// Purpose: groups the request, tone settings and sample result of harmonic_synth.
// Ports: none; master = note sequencer side, slave = harmonic_synth side.
interface harmonic_synth_if import harmonic_pkg::*; #(
   parameter int NUM_HARMONICS = 3,
   parameter int SAMPLE_W      = 16
) ();

   logic                          play_enable;
   logic                          generate_next_sample;
   logic [STEP_W-1:0]             step_size;
   logic [2*NUM_HARMONICS-1:0]    weights;
   logic signed [SAMPLE_W-1:0]    harmonic_out;
   logic                          sample_ready;

   modport master (
      output play_enable, generate_next_sample, step_size, weights,
      input  harmonic_out, sample_ready
   );

   modport slave (
      input  play_enable, generate_next_sample, step_size, weights,
      output harmonic_out, sample_ready
   );

endinterface

// File: rtl/sine_lookup.sv
// rtl/sine_lookup.sv - full-wave sine from the quarter-wave table, 1-cycle latency
// Purpose: unfolds quadrant 0..3 into rom[a], rom[~a], -rom[a], -rom[~a].
// Ports: clk; quad, addr (phase fields); sample (signed, one cycle after quad/addr).
module sine_lookup import harmonic_pkg::*; #(
   parameter int SAMPLE_W = 16
) (
   input  logic                       clk,
   input  logic [QUAD_W-1:0]          quad,
   input  logic [ADDR_W-1:0]          addr,
   output logic signed [SAMPLE_W-1:0] sample
);

   logic [ADDR_W-1:0]          rom_addr;
   logic [SAMPLE_W-2:0]        rom_data;
   logic                       neg_q;
   logic signed [SAMPLE_W-1:0] mag;

   // Odd quadrants read the table backwards (falling half of each lobe).
   assign rom_addr = quad[0] ? ~addr : addr;

   sine_rom #(.ADDR_W(ADDR_W), .DATA_W(SAMPLE_W - 1)) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   // Sign follows the table read by one cycle so it lines up with rom_data.
   always_ff @(posedge clk) begin
      neg_q <= quad[1];
   end

   assign mag    = $signed({1'b0, rom_data});
   assign sample = neg_q ? -mag : mag;

endmodule

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - quarter-wave sine table with registered read
// Purpose: rom[a] = a*(2^(ADDR_W+1)-a) scaled so rom[2^ADDR_W-1] is full scale.
// Ports: clk; addr (table index); data (unsigned magnitude, valid one cycle after addr).
module sine_rom #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam int PROD_W = 2 * ADDR_W + 1;
   localparam int SHIFT  = 2 * ADDR_W - DATA_W;
   localparam logic [PROD_W-1:0] SPAN = PROD_W'(2 ** (ADDR_W + 1));

   logic [PROD_W-1:0] ext;
   logic [PROD_W-1:0] prod;

   // Parabolic quarter-wave: zero at index 0, peak at the last index.
   always_comb begin
      ext  = PROD_W'(addr);
      prod = ext * (SPAN - ext);
   end

   always_ff @(posedge clk) begin
      data <= DATA_W'(prod >> SHIFT);
   end

endmodule

// File: rtl/harmonic_synth.sv
// rtl/harmonic_synth.sv - time-multiplexed multi-harmonic tone generator
// Purpose: per request, sums weighted sine samples of harmonics 1..N over one shared lookup.
// Ports: clk; reset (sync, active-high); bus (slave: play_enable, generate_next_sample,
//        step_size, weights in; harmonic_out, sample_ready out).
module harmonic_synth import harmonic_pkg::*; #(
   parameter int NUM_HARMONICS = 3,
   parameter int SAMPLE_W      = SAMPLE_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   harmonic_synth_if.slave bus
);

   localparam int H_W     = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
   localparam int H_SLOTS = 1 << H_W;
   localparam int ACC_W   = SAMPLE_W + $clog2(NUM_HARMONICS) + 1;
   localparam int SAT_HI  = (SAMPLE_W == SAMPLE_W_DEF) ? SAT_MAX : sat_max(SAMPLE_W);
   localparam int SAT_LO  = (SAMPLE_W == SAMPLE_W_DEF) ? SAT_MIN : -sat_max(SAMPLE_W) - 1;
   localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(SAT_HI);
   localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(SAT_LO);
   localparam logic [H_W-1:0] H_LAST = H_W'(NUM_HARMONICS - 1);

   state_e state, state_nxt;
   logic [H_W-1:0]             h;
   // Padded to a power of two so h indexes cleanly; slots >= NUM_HARMONICS stay zero.
   logic [PHASE_W-1:0]         phase [H_SLOTS];
   logic signed [ACC_W-1:0]    acc;
   logic                       issue_d;
   weight_e                    wt_d;

   logic                       start, issue, finish;
   logic [PHASE_W-1:0]         cur_phase, step_mult;
   logic [2*H_SLOTS-1:0]       w_pad;
   weight_e                    cur_w;
   logic signed [SAMPLE_W-1:0] lk_sample, weighted, sat_val;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      issue     = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: if (bus.generate_next_sample) begin
            start     = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            issue = 1'b1;
            if (h == H_LAST) state_nxt = S_DRAIN;
         end
         S_DRAIN: state_nxt = S_OUT;
         S_OUT: begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cur_phase = phase[h];
      w_pad     = (2*H_SLOTS)'(bus.weights);
      cur_w     = weight_e'(w_pad[{h, 1'b0} +: 2]);
      step_mult = PHASE_W'(bus.step_size) * (PHASE_W'(h) + PHASE_W'(1));
   end

   sine_lookup #(.SAMPLE_W(SAMPLE_W)) u_lookup (
      .clk    (clk),
      .quad   (cur_phase[PHASE_W-1 -: QUAD_W]),
      .addr   (cur_phase[FRAC_W +: ADDR_W]),
      .sample (lk_sample)
   );

   // The weight travels with the issue so it applies to the word returning a cycle later.
   always_comb begin
      case (wt_d)
         W_ZERO:    weighted = '0;
         W_QUARTER: weighted = lk_sample >>> 2;
         W_HALF:    weighted = lk_sample >>> 1;
         default:   weighted = lk_sample;
      endcase
      if (acc > ACC_HI)      sat_val = SAMPLE_W'(ACC_HI);
      else if (acc < ACC_LO) sat_val = SAMPLE_W'(ACC_LO);
      else                   sat_val = acc[SAMPLE_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         h                <= '0;
         acc              <= '0;
         issue_d          <= 1'b0;
         wt_d             <= W_ZERO;
         bus.harmonic_out <= '0;
         bus.sample_ready <= 1'b0;
         for (int i = 0; i < H_SLOTS; i++) phase[i] <= '0;
      end else begin
         state            <= state_nxt;
         issue_d          <= issue;
         wt_d             <= cur_w;
         bus.sample_ready <= finish;
         if (start) begin
            acc <= '0;
            h   <= '0;
         end else begin
            if (issue_d) acc <= acc + ACC_W'(weighted);
            if (issue) begin
               h <= h + H_W'(1);
               // Lookup already used the pre-update phase this cycle.
               if (bus.play_enable) phase[h] <= cur_phase + step_mult;
            end
         end
         if (finish) bus.harmonic_out <= bus.play_enable ? sat_val : '0;
      end
   end

endmodule
